// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core and the loader: one access in flight, fixed read latency.
// Optional performance counters are compiled in when DMEM_ARB_PERF_EN is defined; otherwise the perf ports read 0.
module dmem_arbiter #(
  parameter int unsigned MEM_LAT     = 1,
  parameter bit          LOADER_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic        l_rvalid,
  output logic [31:0] l_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        core_stall,
  output logic        busy,
  output logic [31:0] perf_c_grants,
  output logic [31:0] perf_l_grants,
  output logic [31:0] perf_conflicts
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_e;

  localparam logic       OWN_CORE   = 1'b0;
  localparam logic       OWN_LOADER = 1'b1;
  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic        both_req;
  logic        pick_loader;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_CORE;
      last_owner_q <= OWN_LOADER;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      lat_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      lat_cnt_q    <= lat_cnt_d;
    end
  end

  // Both requesting: fixed loader priority, or whoever did not own the last access.
  assign both_req    = c_req & l_req;
  assign pick_loader = both_req ? (LOADER_PRIO || last_owner_q == OWN_CORE) : l_req;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (c_req || l_req) state_d = S_ACCESS;
      S_ACCESS: state_d = (MEM_LAT == 1) ? S_RESP : S_WAIT;
      S_WAIT:   if (lat_cnt_q == 4'd1) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    lat_cnt_d    = lat_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (c_req || l_req) begin
          owner_d      = pick_loader;
          last_owner_d = pick_loader;
          we_d         = pick_loader ? l_we    : c_we;
          addr_d       = pick_loader ? l_addr  : c_addr;
          wdata_d      = pick_loader ? l_wdata : c_wdata;
        end
      end
      S_ACCESS: begin
        lat_cnt_d = LAT_LOAD;
        if (MEM_LAT == 1) rdata_d = m_rdata;
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) rdata_d = m_rdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    m_en     = (state_q == S_ACCESS);
    m_we     = m_en & we_q;
    m_addr   = m_en ? addr_q  : '0;
    m_wdata  = m_en ? wdata_q : '0;
    c_gnt    = m_en & (owner_q == OWN_CORE);
    l_gnt    = m_en & (owner_q == OWN_LOADER);
    c_rvalid = (state_q == S_RESP) & (owner_q == OWN_CORE);
    l_rvalid = (state_q == S_RESP) & (owner_q == OWN_LOADER);
    c_rdata  = c_rvalid ? rdata_q : '0;
    l_rdata  = l_rvalid ? rdata_q : '0;
    busy     = (state_q != S_IDLE);
    // The core advances in its rvalid cycle, so the stall drops there.
    core_stall = (c_req | (busy & (owner_q == OWN_CORE))) & ~c_rvalid & ~rst;
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_c_q, perf_c_d;
  logic [31:0] perf_l_q, perf_l_d;
  logic [31:0] perf_x_q, perf_x_d;

  always_comb begin
    perf_c_d = perf_c_q;
    perf_l_d = perf_l_q;
    perf_x_d = perf_x_q;
    if (c_gnt && perf_c_q != 32'hFFFF_FFFF) perf_c_d = perf_c_q + 32'd1;
    if (l_gnt && perf_l_q != 32'hFFFF_FFFF) perf_l_d = perf_l_q + 32'd1;
    if (state_q == S_IDLE && both_req && perf_x_q != 32'hFFFF_FFFF) perf_x_d = perf_x_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_c_q <= '0;
      perf_l_q <= '0;
      perf_x_q <= '0;
    end else begin
      perf_c_q <= perf_c_d;
      perf_l_q <= perf_l_d;
      perf_x_q <= perf_x_d;
    end
  end

  assign perf_c_grants  = perf_c_q;
  assign perf_l_grants  = perf_l_q;
  assign perf_conflicts = perf_x_q;
`else
  assign perf_c_grants  = '0;
  assign perf_l_grants  = '0;
  assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: three configurations run side by side, each checked every cycle
// against a transaction-level model (grant at T+1, response at T+1+MEM_LAT, arbitration by rule).
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int N_CFG      = 3;
  localparam int RUN_CYCLES = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [N_CFG-1:0] done = '0;

  task automatic check(input int cfg, input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL cfg%0d %s: got %08h expected %08h (t=%0t)", cfg, tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // cfg0: MEM_LAT=2 round-robin; cfg1: MEM_LAT=4 loader priority with mid-access resets; cfg2: MEM_LAT=1 round-robin.
  for (genvar g = 0; g < N_CFG; g++) begin : cfg
    localparam int LAT      = (g == 0) ? 2 : (g == 1) ? 4 : 1;
    localparam bit PRIO     = (g == 1);
    localparam bit RST_TEST = (g == 1);

    logic        rst;
    logic        c_req, c_we, l_req, l_we;
    logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
    logic        c_gnt, c_rvalid, l_gnt, l_rvalid;
    logic [31:0] c_rdata, l_rdata;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        core_stall, busy;
    logic [31:0] perf_c_grants, perf_l_grants, perf_conflicts;

    // Memory device: data is presented only in the cycle MEM_LAT-1 after the strobe, junk otherwise.
    logic [31:0] mem [64];
    logic [31:0] hold_addr, junk;
    int          age;
    always_comb m_rdata = (age == LAT) ? mem[hold_addr[7:2]] : junk;

    dmem_arbiter #(.MEM_LAT(LAT), .LOADER_PRIO(PRIO)) u_dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .core_stall(core_stall), .busy(busy),
      .perf_c_grants(perf_c_grants), .perf_l_grants(perf_l_grants), .perf_conflicts(perf_conflicts)
    );

    // Reference model: one transaction record plus a shadow memory.
    logic [31:0] exp_mem [64];
    bit          txn, own, t_we, last_own;
    int          t_acc, t_resp;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic [31:0] pc_g, pl_g, pconf;
    bit          c_pend, c_out, l_pend, l_out, first_c, rst_cycle;
    bit          in_flight, acc, resp, win;
    int          pct;

    initial begin : run
      rst = 1'b1;
      c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
      l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
      age = 0; hold_addr = '0; junk = '0;
      for (int i = 0; i < 64; i++) begin
        mem[i] = $urandom;
        exp_mem[i] = mem[i];
      end
      mem[16] = 32'hDEADBEEF;
      exp_mem[16] = 32'hDEADBEEF;
      txn = 0; last_own = 1; pc_g = '0; pl_g = '0; pconf = '0;
      c_pend = 0; c_out = 0; l_pend = 0; l_out = 0; first_c = 1; pct = 100;
      t_acc = 0; t_resp = 0; own = 0; t_we = 0; t_addr = '0; t_wdata = '0; t_rdata = '0;
      @(posedge clk);
      #1;
      for (int k = 0; k < RUN_CYCLES; k++) begin
        // ---- drive inputs for cycle k ----
        if (k % 128 == 0) begin
          case ($urandom_range(0, 2))
            0: pct = 100;
            1: pct = 50;
            default: pct = 10;
          endcase
        end
        rst_cycle = (k < 3) ||
                    (RST_TEST && txn && k > t_acc && k < t_resp && $urandom_range(0, 99) < 5);
        if (rst_cycle) begin
          rst = 1'b1;
          c_req = 0; l_req = 0;
          c_pend = 0; c_out = 0; l_pend = 0; l_out = 0;
          txn = 0; last_own = 1; pc_g = '0; pl_g = '0; pconf = '0;
          #1;
          check(g, "rst_now_busy",     32'(busy),     32'd0);
          check(g, "rst_now_m_en",     32'(m_en),     32'd0);
          check(g, "rst_now_m_addr",   m_addr,        32'd0);
          check(g, "rst_now_c_rvalid", 32'(c_rvalid), 32'd0);
          check(g, "rst_now_l_rvalid", 32'(l_rvalid), 32'd0);
          check(g, "rst_now_stall",    32'(core_stall), 32'd0);
          check(g, "rst_now_perf_l",   perf_l_grants, 32'd0);
        end else begin
          rst = 1'b0;
          if (!c_pend && !c_out && $urandom_range(0, 99) < pct) begin
            c_pend = 1; c_we = 1'($urandom_range(0, 1)); c_addr = $urandom; c_wdata = $urandom;
            if (g == 0 && first_c) begin
              c_we = 0; c_addr = 32'h40; first_c = 0;
            end
          end
          if (!l_pend && !l_out && $urandom_range(0, 99) < pct) begin
            l_pend = 1; l_we = 1'($urandom_range(0, 1)); l_addr = $urandom; l_wdata = $urandom;
          end
          c_req = c_pend;
          l_req = l_pend;
          if (!c_pend) begin c_we = 1'($urandom_range(0, 1)); c_addr = $urandom; c_wdata = $urandom; end
          if (!l_pend) begin l_we = 1'($urandom_range(0, 1)); l_addr = $urandom; l_wdata = $urandom; end
        end

        // ---- check outputs mid-cycle ----
        @(negedge clk);
        in_flight = txn && k >= t_acc && k <= t_resp;
        acc  = txn && k == t_acc;
        resp = txn && k == t_resp;
        check(g, "c_gnt",    32'(c_gnt),    32'(acc && !own));
        check(g, "l_gnt",    32'(l_gnt),    32'(acc && own));
        check(g, "c_rvalid", 32'(c_rvalid), 32'(resp && !own));
        check(g, "l_rvalid", 32'(l_rvalid), 32'(resp && own));
        check(g, "m_en",     32'(m_en),     32'(acc));
        check(g, "m_we",     32'(m_we),     32'(acc && t_we));
        check(g, "m_addr",   m_addr,        acc ? t_addr : 32'd0);
        check(g, "m_wdata",  m_wdata,       acc ? t_wdata : 32'd0);
        check(g, "busy",     32'(busy),     32'(in_flight));
        check(g, "core_stall", 32'(core_stall), 32'((c_req || (in_flight && !own)) && !(resp && !own)));
        if (resp && !t_we) begin
          if (own) check(g, "l_rdata", l_rdata, t_rdata);
          else     check(g, "c_rdata", c_rdata, t_rdata);
        end
        if (in_flight) begin
          if (own) check(g, "c_rdata_idle", c_rdata, 32'd0);
          else     check(g, "l_rdata_idle", l_rdata, 32'd0);
        end
`ifdef DMEM_ARB_PERF_EN
        check(g, "perf_c_grants",  perf_c_grants,  pc_g);
        check(g, "perf_l_grants",  perf_l_grants,  pl_g);
        check(g, "perf_conflicts", perf_conflicts, pconf);
`else
        check(g, "perf_c_grants",  perf_c_grants,  32'd0);
        check(g, "perf_l_grants",  perf_l_grants,  32'd0);
        check(g, "perf_conflicts", perf_conflicts, 32'd0);
`endif

        // ---- memory device reacts to the strobe ----
        if (m_en) begin
          if (m_we) mem[m_addr[7:2]] = m_wdata;
          hold_addr = m_addr;
          age = 1;
        end else if (age != 0 && age < 31) begin
          age++;
        end
        junk = $urandom;

        // ---- advance the model past the coming edge ----
        if (!rst_cycle) begin
          if (acc) begin
            t_rdata = exp_mem[t_addr[7:2]];
            if (t_we) exp_mem[t_addr[7:2]] = t_wdata;
            if (own) begin l_pend = 0; l_out = 1; pl_g = sat_inc(pl_g); end
            else     begin c_pend = 0; c_out = 1; pc_g = sat_inc(pc_g); end
          end
          if (resp) begin
            if (own) l_out = 0; else c_out = 0;
            txn = 0;
          end
          if (!in_flight) begin
            if (c_req && l_req) pconf = sat_inc(pconf);
            if (c_req || l_req) begin
              win = (c_req && l_req) ? (PRIO || !last_own) : l_req;
              txn = 1; own = win; last_own = win;
              t_acc = k + 1; t_resp = k + 1 + LAT;
              t_we    = win ? l_we    : c_we;
              t_addr  = win ? l_addr  : c_addr;
              t_wdata = win ? l_wdata : c_wdata;
            end
          end
        end
        @(posedge clk);
        #1;
      end
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < RUN_CYCLES + 200; i++) begin
      @(posedge clk);
      if (&done) break;
    end
    check(0, "all_cfgs_done", 32'(done), 32'((1 << N_CFG) - 1));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the core load/store path (c_*) and a program/data loader (l_*).
- Sits between the single-cycle core, the loader and DMEM. Drives the memory enable, write and address lines, and stalls the core while its access is pending.
- One access in flight at a time. Memory read latency is a fixed parameter.

Parameters:
- MEM_LAT, 1, cycles from m_en to m_rdata valid. Legal range is 1..15. With 1, m_rdata is valid in the m_en cycle.
- LOADER_PRIO, 0, selects arbitration. 0 = round-robin; 1 = loader has fixed priority.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- c_req  in  1  core request; held until c_gnt
- c_we  in  1  core write (1) or read (0)
- c_addr  in  32  core byte address
- c_wdata  in  32  core write data
- c_gnt  out  1  core access issued (one-cycle pulse)
- c_rvalid  out  1  core access complete (one-cycle pulse)
- c_rdata  out  32  core read data, valid with c_rvalid
- l_req, l_we, l_addr, l_wdata, l_gnt, l_rvalid, l_rdata: same as the core set, for the loader
- m_en  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data
- core_stall  out  1  core must hold its PC
- busy  out  1  state != IDLE
- perf_c_grants  out  32  number of core grants
- perf_l_grants  out  32  number of loader grants
- perf_conflicts  out  32  cycles in IDLE with both requests high

Behaviour:
- Reset (rst=1, takes effect immediately): state=IDLE, all outputs 0, lat_cnt=0, last_owner=loader.
- Reset mid-access aborts the access with no rvalid. A write already strobed is not undone.
- The FSM has four states.
  - IDLE: if any request is high, register the winner's we/addr/wdata and owner; go to ACCESS. Otherwise stay.
  - ACCESS (one cycle): m_en=1, m_we/m_addr/m_wdata = latched values, owner's gnt=1. Load lat_cnt=MEM_LAT-1. If MEM_LAT==1 capture m_rdata and go to RESP; otherwise go to WAIT.
  - WAIT: m_en=0 and lat_cnt decrements. When lat_cnt==1, capture m_rdata and go to RESP.
  - RESP (one cycle): owner's rvalid=1 and owner's rdata = captured data; go to IDLE.
- Timing: a request first seen in IDLE cycle T gives gnt in T+1, rvalid in T+1+MEM_LAT, and the next grant no earlier than T+MEM_LAT+3.
- Writes also complete with rvalid. rdata for a write is the m_rdata captured (don't-care). Benches must check rdata on reads only.
- Arbitration (evaluated in IDLE only):
  - A single requester wins.
  - With both requesting: if LOADER_PRIO=1 the loader wins; otherwise the requester not equal to last_owner wins.
  - last_owner updates on every grant.
- Requester rules: request and its fields are held stable until gnt. The request may drop in the cycle after gnt. A requester does not re-request before its rvalid.
- Non-owner outputs: gnt, rvalid and rdata are 0 during the other requester's access.
- m_* outputs are 0 outside ACCESS.
- core_stall = c_req | (owner==core & state!=IDLE), masked to 0 in the c_rvalid cycle. This is combinational; the core advances on the c_rvalid cycle.
- Addresses are passed through unmodified; there is no alignment check.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- When defined:
  - perf_c_grants / perf_l_grants increment on each c_gnt / l_gnt.
  - perf_conflicts increments each IDLE cycle with c_req & l_req.
  - All three saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: the counter logic is absent, and the three perf ports remain present, tied to 0.

Test Plan:
- MEM_LAT=2. Core read of addr 0x40 with memory returning 0xDEADBEEF; c_req rises in cycle 0. Required: c_gnt, m_en=1, m_addr=0x40 in cycle 1; c_rvalid with c_rdata=0xDEADBEEF in cycle 3; core_stall=1 in cycles 0-2 and 0 in cycle 3.
- Loader write to 0x100 with data 0x12345678. Required: m_we=1, m_wdata=0x12345678, l_gnt in the ACCESS cycle; l_rvalid MEM_LAT cycles later; c_gnt, c_rvalid and core_stall stay 0.
- Round-robin, LOADER_PRIO=0, both requests held continuously after reset, each re-raised after its rvalid. Required grant order: core, loader, core, loader. No back-to-back grants to the same requester.
- Same stimulus with LOADER_PRIO=1. Required: every grant goes to the loader, core_stall stays 1; with DMEM_ARB_PERF_EN, perf_c_grants=0 and perf_conflicts equals the number of IDLE cycles with both requests high.
- Reset mid-access: assert rst during WAIT (MEM_LAT=4). Required: all outputs 0 immediately, no rvalid. After release, a new core read completes normally.
- MEM_LAT=1, three back-to-back core reads. Required: each rvalid arrives 2 cycles after its request, the next gnt arrives 2 cycles after the previous rvalid, and perf_c_grants=3 when the macro is defined.
